// File: rtl/cpu_divide_iterative_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface cpu_divide_iterative_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic             i_signed;
  logic [WIDTH-1:0] i_numerator;
  logic [WIDTH-1:0] i_denominator;
  logic             i_kill;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic [WIDTH-1:0] o_remainder;

  modport master (
    output i_valid, i_signed, i_numerator, i_denominator, i_kill, i_ready,
    input  o_ready, o_valid, o_result, o_remainder
  );

  modport slave (
    input  i_valid, i_signed, i_numerator, i_denominator, i_kill, i_ready,
    output o_ready, o_valid, o_result, o_remainder
  );
endinterface

// File: rtl/cpu_divide_iterative.sv
// Iterative radix-2^STEPS restoring divider with RISC-V divide-by-zero/overflow semantics.
// Latency WIDTH/STEPS+1 edges (1 for special cases); one operation in flight, i_kill flushes.
module cpu_divide_iterative #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  cpu_divide_iterative_if.slave   bus
);
  localparam int K  = WIDTH / STEPS;
  localparam int CW = $clog2(K + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN = ONE << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITERATE, FIXUP, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, den_q, den_d;
  logic [WIDTH-1:0] res_q, res_d, rmd_q, rmd_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, vld_q, vld_d;

  logic             num_neg, den_neg, div_zero, ovf, accept;
  logic [WIDTH-1:0] num_abs, den_abs;
  logic [WIDTH-1:0] s_rem, s_quo;
  logic [WIDTH:0]   s_trial, s_diff;

  assign num_neg  = bus.i_signed & bus.i_numerator[WIDTH-1];
  assign den_neg  = bus.i_signed & bus.i_denominator[WIDTH-1];
  assign num_abs  = num_neg ? (~bus.i_numerator + ONE) : bus.i_numerator;
  assign den_abs  = den_neg ? (~bus.i_denominator + ONE) : bus.i_denominator;
  assign div_zero = (bus.i_denominator == '0);
  assign ovf      = bus.i_signed & (bus.i_numerator == MIN) & (&bus.i_denominator);
  assign accept   = bus.i_valid & (state_q == IDLE) & ~bus.i_kill;

  // Dividend bits shift out of the quotient register's MSB while quotient bits enter at the LSB.
  always_comb begin
    s_rem   = rem_q;
    s_quo   = quo_q;
    s_trial = '0;
    s_diff  = '0;
    for (int i = 0; i < STEPS; i++) begin
      s_trial = {s_rem, s_quo[WIDTH-1]};
      s_diff  = s_trial - {1'b0, den_q};
      s_quo   = {s_quo[WIDTH-2:0], ~s_diff[WIDTH]};
      s_rem   = s_diff[WIDTH] ? s_trial[WIDTH-1:0] : s_diff[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    den_d   = den_q;
    res_d   = res_q;
    rmd_d   = rmd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = CW'(K);
          den_d = den_abs;
          if (div_zero || ovf) begin
            // Final values are loaded directly; FIXUP passes them through unchanged.
            quo_d   = div_zero ? '1 : bus.i_numerator;
            rem_d   = div_zero ? bus.i_numerator : '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIXUP;
          end else begin
            quo_d   = num_abs;
            rem_d   = '0;
            qneg_d  = num_neg ^ den_neg;
            rneg_d  = num_neg;
            state_d = ITERATE;
          end
        end
      end
      ITERATE: begin
        quo_d = s_quo;
        rem_d = s_rem;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        res_d   = qneg_q ? (~quo_q + ONE) : quo_q;
        rmd_d   = rneg_q ? (~rem_q + ONE) : rem_q;
        vld_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.i_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.i_kill) begin
      state_d = IDLE;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      res_q   <= '0;
      rmd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      res_q   <= res_d;
      rmd_q   <= rmd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.o_ready     = (state_q == IDLE);
  assign bus.o_valid     = vld_q;
  assign bus.o_result    = res_q;
  assign bus.o_remainder = rmd_q;
endmodule

// File: tb/tb_cpu_divide_iterative.sv
// Directed and table-driven checks of the iterative divider at 32/1, 8/2 and 8/4.
module tb_cpu_divide_iterative;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_divide_iterative_if #(.WIDTH(32)) d32 ();
  cpu_divide_iterative_if #(.WIDTH(8))  e2 ();
  cpu_divide_iterative_if #(.WIDTH(8))  e4 ();

  cpu_divide_iterative #(.WIDTH(32), .STEPS(1)) u32 (.i_clock(clk), .i_reset_n(rst_n), .bus(d32.slave));
  cpu_divide_iterative #(.WIDTH(8),  .STEPS(2)) u82 (.i_clock(clk), .i_reset_n(rst_n), .bus(e2.slave));
  cpu_divide_iterative #(.WIDTH(8),  .STEPS(4)) u84 (.i_clock(clk), .i_reset_n(rst_n), .bus(e4.slave));

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    bit          sgn;
    logic [31:0] n;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic issue32(input bit sgn, input logic [31:0] n, input logic [31:0] d);
    int t = 0;
    while (!d32.o_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) chk("ready_timeout", 64'(t), 64'(0));
    d32.i_signed = sgn; d32.i_numerator = n; d32.i_denominator = d; d32.i_valid = 1'b1;
    @(posedge clk); #1;
    d32.i_valid = 1'b0;
    d32.i_numerator = $urandom; d32.i_denominator = $urandom; d32.i_signed = ~sgn;
  endtask

  task automatic wait32(input string nm, input logic [31:0] q, input logic [31:0] r, input int lat);
    int c = 0;
    bit busy_ok = 1'b1;
    while (!d32.o_valid && c < 100) begin
      @(posedge clk); #1; c++;
      if (d32.o_ready) busy_ok = 1'b0;
    end
    chk({nm, "_lat"}, 64'(c), 64'(lat));
    chk({nm, "_q"}, 64'(d32.o_result), 64'(q));
    chk({nm, "_r"}, 64'(d32.o_remainder), 64'(r));
    chk({nm, "_busy"}, 64'(busy_ok), 64'(1));
  endtask

  function automatic void gold8(input bit s, input logic [7:0] n, input logic [7:0] d,
                                output logic [7:0] q, output logic [7:0] r);
    int ni, di;
    if (d == 8'h00) begin
      q = 8'hFF; r = n;
    end else if (s && n == 8'h80 && d == 8'hFF) begin
      q = 8'h80; r = 8'h00;
    end else if (s) begin
      ni = $signed(n); di = $signed(d);
      q = 8'(ni / di); r = 8'(ni % di);
    end else begin
      q = n / d; r = n % d;
    end
  endfunction

  task automatic op8(input bit s, input logic [7:0] n, input logic [7:0] d);
    logic [7:0] q, r, q2, r2, q4, r4;
    int c = 0, l2 = -1, l4 = -1;
    gold8(s, n, d, q, r);
    e2.i_signed = s; e2.i_numerator = n; e2.i_denominator = d; e2.i_valid = 1'b1;
    e4.i_signed = s; e4.i_numerator = n; e4.i_denominator = d; e4.i_valid = 1'b1;
    @(posedge clk); #1;
    e2.i_valid = 1'b0; e4.i_valid = 1'b0;
    q2 = 'x; r2 = 'x; q4 = 'x; r4 = 'x;
    while ((l2 < 0 || l4 < 0) && c < 30) begin
      @(posedge clk); #1; c++;
      if (l2 < 0 && e2.o_valid) begin l2 = c; q2 = e2.o_result; r2 = e2.o_remainder; end
      if (l4 < 0 && e4.o_valid) begin l4 = c; q4 = e4.o_result; r4 = e4.o_remainder; end
    end
    @(posedge clk); #1;
    if (d == 8'h00 || (s && n == 8'h80 && d == 8'hFF)) begin
      chk("s2_lat", 64'(l2), 64'(1));
      chk("s4_lat", 64'(l4), 64'(1));
    end else begin
      chk("s2_lat", 64'(l2), 64'(5));
      chk("s4_lat", 64'(l4), 64'(3));
    end
    chk("s2_q", {s, n, d, q2}, {s, n, d, q});
    chk("s2_r", {s, n, d, r2}, {s, n, d, r});
    chk("s4_q", {s, n, d, q4}, {s, n, d, q});
    chk("s4_r", {s, n, d, r4}, {s, n, d, r});
  endtask

  initial begin
    logic [7:0] corner [8];
    bit seen;
    corner = '{8'h00, 8'h01, 8'h05, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

    vt[0]  = '{0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vt[1]  = '{1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33};
    vt[2]  = '{1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33};
    vt[3]  = '{0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          33};
    vt[4]  = '{1, 32'd1234,       32'd0,          32'hFFFFFFFF,   32'd1234,       1};
    vt[5]  = '{0, 32'd1234,       32'd0,          32'hFFFFFFFF,   32'd1234,       1};
    vt[6]  = '{1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1};
    vt[7]  = '{0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   33};
    vt[8]  = '{1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          33};
    vt[9]  = '{0, 32'd0,          32'd5,          32'd0,          32'd0,          33};
    vt[10] = '{1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   33};

    d32.i_valid = 0; d32.i_signed = 0; d32.i_numerator = 0; d32.i_denominator = 0;
    d32.i_kill = 0; d32.i_ready = 1;
    e2.i_valid = 0; e2.i_signed = 0; e2.i_numerator = 0; e2.i_denominator = 0;
    e2.i_kill = 0; e2.i_ready = 1;
    e4.i_valid = 0; e4.i_signed = 0; e4.i_numerator = 0; e4.i_denominator = 0;
    e4.i_kill = 0; e4.i_ready = 1;

    #2;
    chk("rst_state", {d32.o_ready, d32.o_valid, d32.o_result, d32.o_remainder}, {1'b1, 1'b0, 64'h0});
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      issue32(vt[i].sgn, vt[i].n, vt[i].d);
      wait32($sformatf("vec%0d", i), vt[i].q, vt[i].r, vt[i].lat);
      @(posedge clk); #1;
    end

    // Backpressure then a request queued while the result is still held.
    d32.i_ready = 1'b0;
    issue32(0, 32'd200, 32'd10);
    wait32("bp", 32'd20, 32'd0, 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {d32.o_valid, d32.o_ready, d32.o_result, d32.o_remainder}, {1'b1, 1'b0, 32'd20, 32'd0});
    end
    d32.i_ready = 1'b1;
    d32.i_signed = 0; d32.i_numerator = 32'd81; d32.i_denominator = 32'd9; d32.i_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {d32.o_valid, d32.o_ready}, {1'b0, 1'b1});
    @(posedge clk); #1;
    d32.i_valid = 1'b0;
    wait32("b2b", 32'd9, 32'd0, 33);
    @(posedge clk); #1;

    // Kill mid-iteration with a competing request.
    issue32(0, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    d32.i_kill = 1'b1; d32.i_valid = 1'b1; d32.i_numerator = 32'd77; d32.i_denominator = 32'd7;
    @(posedge clk); #1;
    chk("kill_idle", {d32.o_ready, d32.o_valid}, {1'b1, 1'b0});
    d32.i_kill = 1'b0; d32.i_valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (d32.o_valid || !d32.o_ready) seen = 1'b1;
    end
    chk("kill_no_valid", 64'(seen), 64'(0));
    issue32(0, 32'd50, 32'd5);
    wait32("after_kill", 32'd10, 32'd0, 33);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an iteration.
    issue32(1, 32'hFFFFFFFF, 32'd3);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1 chk("mid_rst", {d32.o_ready, d32.o_valid, d32.o_result, d32.o_remainder}, {1'b1, 1'b0, 64'h0});
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    issue32(0, 32'd100, 32'd7);
    wait32("post_rst", 32'd14, 32'd2, 33);
    @(posedge clk); #1;

    // Narrow instances: every corner pair, then random operands.
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++)
          op8(s[0], corner[a], corner[b]);
    for (int i = 0; i < 300; i++)
      op8(1'($urandom), 8'($urandom), 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/cpu_divide_iterative.md
Name: cpu_divide_iterative

Overview:
- Multi-cycle, parametrised integer divider for the CPU execute stage; the successor to the fixed 32-bit pipelined divider.
- Uses a shared radix-2^STEPS restoring datapath instead of vendor divide IP, so it is portable and small.
- Adds a valid/ready handshake, configurable width and throughput, pipeline-flush abort, and RISC-V M-extension divide-by-zero and overflow semantics.
- Sits beside the multiplier and is consumed by the DIV/DIVU/REM/REMU writeback path.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- STEPS, 1, quotient bits resolved per cycle; 1, 2 or 4, and must divide WIDTH.

Ports:
- i_clock  in  1  clock; all state updates on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  divider can accept a request.
- i_signed  in  1  1 = signed operation (DIV/REM), 0 = unsigned.
- i_numerator  in  WIDTH  dividend.
- i_denominator  in  WIDTH  divisor.
- i_kill  in  1  synchronous flush; abandons any operation.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_result  out  WIDTH  quotient.
- o_remainder  out  WIDTH  remainder.

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_ready=1, o_valid=0, o_result=0, o_remainder=0, iteration counter=0.
- States: IDLE, ITERATE, FIXUP, DONE.
- o_ready = (state==IDLE). A request is accepted on a rising edge where i_valid & o_ready & !i_kill.
- On the accepting edge (edge 0), capture:
  - |numerator| and |denominator| (absolute value only when i_signed; otherwise raw);
  - quotient sign = num_msb ^ den_msb, and remainder sign = num_msb (signed only);
  - special-case flags;
  - K = WIDTH/STEPS into the counter.
- Special cases are detected at accept and go straight to FIXUP, skipping ITERATE:
  - denominator==0: result = all ones, remainder = numerator (unmodified), for both signed and unsigned.
  - signed overflow (numerator = 1 followed by WIDTH-1 zeros, denominator = all ones): result = numerator, remainder = 0.
- ITERATE:
  - Each edge performs STEPS restoring shift/subtract steps on the WIDTH-bit partial remainder (WIDTH+1-bit subtractor), MSB-first, then decrements the counter.
  - Leave to FIXUP when the counter reaches 0, i.e. K edges (edges 1..K).
- FIXUP (one edge):
  - Negate the quotient if its sign is set; negate the remainder if its sign is set.
  - Both are two's complement modulo 2^WIDTH.
  - Load o_result/o_remainder, set o_valid, go to DONE.
- Latency from accepting edge to o_valid visible:
  - normal: K+1 edges (33 for WIDTH=32, STEPS=1; 9 for STEPS=4);
  - special case: 1 edge.
- DONE:
  - o_valid=1; o_result/o_remainder held stable while !i_ready.
  - On an edge with i_ready: o_valid=0, go to IDLE.
  - o_ready stays 0 during DONE, so the earliest next accept is the edge after the i_ready edge.
- i_kill:
  - Highest priority: on any edge with i_kill=1, go to IDLE and clear o_valid.
  - Result registers keep their stale values and are don't-care.
  - No request is accepted on that edge even if i_valid=1.
  - No o_valid is ever produced for a killed operation.
- Input operands may change after the accepting edge without affecting the operation.
- Unsigned semantics ignore the operand MSB sign meaning entirely.
- Remainder sign always follows the dividend (truncating division); the invariant numerator == result*denominator + remainder holds modulo 2^WIDTH in all cases.
- Mid-operation reset: outputs return to reset values immediately on i_reset_n=0, regardless of state.

Test Plan:
1. Unsigned, WIDTH=32, STEPS=1: 100 / 7 -> after 33 edges o_valid=1, o_result=14, o_remainder=2; o_ready low for the whole interval.
2. Signed: -7 / 2 (0xFFFFFFF9 / 2) -> result 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); 7 / -2 -> -3, remainder 1. Unsigned 0xFFFFFFF9 / 2 -> 0x7FFFFFFC, remainder 1.
3. Special cases:
   - 1234 / 0, signed and unsigned -> result 0xFFFFFFFF, remainder 1234.
   - 0x80000000 / 0xFFFFFFFF signed -> result 0x80000000, remainder 0.
   - Both produce o_valid after 1 edge.
4. Backpressure and back-to-back:
   - Hold i_ready=0 for 5 cycles in DONE -> outputs stable, o_valid stays 1.
   - Then i_ready=1 with a new i_valid pending -> accept occurs on the following edge; second result correct.
5. Kill:
   - Assert i_kill on ITERATE edge 10 together with i_valid=1 -> IDLE, no accept, no o_valid.
   - Then 50/5 completes normally with 10, remainder 0.
   - Also assert i_reset_n=0 mid-ITERATE -> outputs zero immediately.
6. Parameter sweep WIDTH=8 and 32, STEPS=1, 2 and 4, with 10k random signed/unsigned operands (including 0, -1 and the most-negative value) checked against a golden model -> latency = WIDTH/STEPS+1 and all results match.
